// File: rtl/booth_acc_stage.sv
// Accumulate stage behind the radix-4 Booth multiplier: sums a frame of signed products
// and holds the frame result, with its beat count and overflow flag, until the consumer takes it.
module booth_acc_stage #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] p,
    input  logic               p_valid,
    input  logic               p_last,
    output logic               p_ready,
    output logic [ACC_W-1:0]   acc,
    output logic [CNT_W-1:0]   acc_cnt,
    output logic               acc_ovf,
    output logic               acc_valid,
    input  logic               acc_ready
);

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               beat;
    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   sum;
    logic               step_ovf;

    assign beat     = p_valid && (state_q == S_ACC);
    assign p_ext    = ACC_W'($signed(p));
    assign sum      = acc_q + p_ext;
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign step_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ACC:   if (beat && p_last) state_d = S_HOLD;
            S_HOLD:  if (acc_ready)      state_d = S_ACC;
            default: state_d = S_ACC;
        endcase
    end

    always_comb begin
        p_ready   = (state_q == S_ACC);
        acc_valid = (state_q == S_HOLD);
        acc       = acc_q;
        acc_cnt   = cnt_q;
        acc_ovf   = ovf_q;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (beat) begin
            acc_d = sum;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            ovf_d = ovf_q | step_ovf;
        end else if ((state_q == S_HOLD) && acc_ready) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule
